// File: rtl/dma_ctrl.sv
// UART <-> shared-RAM DMA controller: RX bytes go into a RAM command buffer, CPU send commands push two RAM bytes to the UART TX.
// Optional feature macro: DMA_GRANT_TIMEOUT_EN (bounded wait for DMA_Ack with sticky Grant_err).
module dma_ctrl #(
    parameter logic [7:0]  RX_BUF_BASE   = 8'h00,
    parameter int unsigned RX_BUF_LEN    = 3,
    parameter logic [7:0]  NEW_INST_ADDR = 8'h03,
    parameter logic [7:0]  TX_MSB_ADDR   = 8'h04,
    parameter logic [7:0]  TX_LSB_ADDR   = 8'h05,
    parameter int unsigned GRANT_TIMEOUT = 255
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       Send_comm,
    output logic       DMA_RQ,
    input  logic       DMA_Ack,
    output logic       READY,
    output logic [7:0] Address,
    output logic [7:0] Data_out,
    input  logic [7:0] Data_in,
    output logic       Write_en,
    output logic       OE,
    input  logic [7:0] RX_Data,
    input  logic       RX_Empty,
    output logic       Data_Read,
    output logic [7:0] TX_Data,
    output logic       TX_Valid,
    input  logic       TX_Ready,
    output logic       Grant_err
);

    if (RX_BUF_LEN < 1 || RX_BUF_LEN > 8 || GRANT_TIMEOUT < 1 || GRANT_TIMEOUT > 65535) begin : g_param_check
        $error("dma_ctrl: parameter out of range");
    end

    localparam logic [3:0] RX_LEN4 = 4'(RX_BUF_LEN);

    typedef enum logic [3:0] {
        IDLE, RX_REQ, RX_WR, RX_FLAG, RELEASE,
        TX_REQ, RD_MSB, LAT_MSB, RD_LSB, LAT_LSB, RELEASE_TX,
        SEND_MSB, WAIT_MSB, SEND_LSB, WAIT_LSB
    } state_t;

    state_t     state;
    logic       send_pending;
    logic [2:0] idx;
    logic [7:0] tx_msb;
    logic [7:0] tx_lsb;
    logic       tx_seen_busy;

`ifdef DMA_GRANT_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(GRANT_TIMEOUT - 1);
    logic [15:0] grant_cnt;
`else
    assign Grant_err = 1'b0;
`endif

    assign READY = (state == IDLE) && !send_pending;

    // Outputs are registered on entry to the state that owns them, so each strobe is visible for exactly that state's cycle.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state        <= IDLE;
            send_pending <= 1'b0;
            idx          <= '0;
            tx_msb       <= '0;
            tx_lsb       <= '0;
            tx_seen_busy <= 1'b0;
            DMA_RQ       <= 1'b0;
            Address      <= '0;
            Data_out     <= '0;
            Write_en     <= 1'b0;
            OE           <= 1'b0;
            Data_Read    <= 1'b0;
            TX_Data      <= '0;
            TX_Valid     <= 1'b0;
`ifdef DMA_GRANT_TIMEOUT_EN
            grant_cnt    <= '0;
            Grant_err    <= 1'b0;
`endif
        end else begin
            Address   <= '0;
            Data_out  <= '0;
            Write_en  <= 1'b0;
            OE        <= 1'b0;
            Data_Read <= 1'b0;
            TX_Valid  <= 1'b0;

            case (state)
                IDLE: begin
`ifdef DMA_GRANT_TIMEOUT_EN
                    grant_cnt <= '0;
`endif
                    if (send_pending) begin
                        state        <= TX_REQ;
                        DMA_RQ       <= 1'b1;
                        send_pending <= 1'b0;
                    end else if (!RX_Empty) begin
                        state  <= RX_REQ;
                        DMA_RQ <= 1'b1;
                    end
                end
                RX_REQ: begin
                    if (DMA_Ack) begin
                        state     <= RX_WR;
                        Address   <= RX_BUF_BASE + {5'd0, idx};
                        Data_out  <= RX_Data;
                        Write_en  <= 1'b1;
                        Data_Read <= 1'b1;
                    end
`ifdef DMA_GRANT_TIMEOUT_EN
                    else if (grant_cnt == TO_LAST) begin
                        Grant_err <= 1'b1;
                        DMA_RQ    <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        grant_cnt <= grant_cnt + 16'd1;
                    end
`endif
                end
                RX_WR: begin
                    if (({1'b0, idx} + 4'd1) == RX_LEN4) begin
                        idx      <= '0;
                        state    <= RX_FLAG;
                        Address  <= NEW_INST_ADDR;
                        Data_out <= 8'hFF;
                        Write_en <= 1'b1;
                    end else begin
                        idx    <= idx + 3'd1;
                        state  <= RELEASE;
                        DMA_RQ <= 1'b0;
                    end
                end
                RX_FLAG: begin
                    state  <= RELEASE;
                    DMA_RQ <= 1'b0;
                end
                RELEASE: begin
                    // Waiting out the old grant keeps a stale DMA_Ack from satisfying the next request.
                    if (!DMA_Ack)
                        state <= IDLE;
                end
                TX_REQ: begin
                    if (DMA_Ack) begin
                        state   <= RD_MSB;
                        Address <= TX_MSB_ADDR;
                        OE      <= 1'b1;
                    end
`ifdef DMA_GRANT_TIMEOUT_EN
                    else if (grant_cnt == TO_LAST) begin
                        Grant_err    <= 1'b1;
                        DMA_RQ       <= 1'b0;
                        send_pending <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        grant_cnt <= grant_cnt + 16'd1;
                    end
`endif
                end
                RD_MSB: state <= LAT_MSB;
                LAT_MSB: begin
                    tx_msb  <= Data_in;
                    state   <= RD_LSB;
                    Address <= TX_LSB_ADDR;
                    OE      <= 1'b1;
                end
                RD_LSB: state <= LAT_LSB;
                LAT_LSB: begin
                    tx_lsb <= Data_in;
                    state  <= RELEASE_TX;
                    DMA_RQ <= 1'b0;
                end
                RELEASE_TX: state <= SEND_MSB;
                SEND_MSB: begin
                    if (TX_Ready) begin
                        TX_Data      <= tx_msb;
                        TX_Valid     <= 1'b1;
                        tx_seen_busy <= 1'b0;
                        state        <= WAIT_MSB;
                    end
                end
                WAIT_MSB: begin
                    if (!TX_Ready)
                        tx_seen_busy <= 1'b1;
                    else if (tx_seen_busy)
                        state <= SEND_LSB;
                end
                SEND_LSB: begin
                    if (TX_Ready) begin
                        TX_Data      <= tx_lsb;
                        TX_Valid     <= 1'b1;
                        tx_seen_busy <= 1'b0;
                        state        <= WAIT_LSB;
                    end
                end
                WAIT_LSB: begin
                    if (!TX_Ready)
                        tx_seen_busy <= 1'b1;
                    else if (tx_seen_busy)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // A new pulse wins over the clear on TX_REQ entry so a request arriving then is not dropped.
            if (Send_comm)
                send_pending <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dma_ctrl.sv
// Bench for dma_ctrl: RAM / RX FIFO / UART TX / bus-grant environment, transaction scoreboard and directed scenarios.
module tb_dma_ctrl;

`ifdef DMA_GRANT_TIMEOUT_EN
    localparam int unsigned TO = 10;
`else
    localparam int unsigned TO = 255;
`endif

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b0;
    logic       Send_comm = 1'b0;
    logic       DMA_Ack = 1'b0;
    logic [7:0] Data_in = 8'h00;
    logic [7:0] RX_Data = 8'h00;
    logic       RX_Empty = 1'b1;
    logic       TX_Ready = 1'b1;
    logic       DMA_RQ, READY, Write_en, OE, Data_Read, TX_Valid, Grant_err;
    logic [7:0] Address, Data_out, TX_Data;

    dma_ctrl #(
        .RX_BUF_BASE  (8'h00),
        .RX_BUF_LEN   (3),
        .NEW_INST_ADDR(8'h03),
        .TX_MSB_ADDR  (8'h04),
        .TX_LSB_ADDR  (8'h05),
        .GRANT_TIMEOUT(TO)
    ) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Send_comm(Send_comm),
        .DMA_RQ(DMA_RQ), .DMA_Ack(DMA_Ack), .READY(READY),
        .Address(Address), .Data_out(Data_out), .Data_in(Data_in),
        .Write_en(Write_en), .OE(OE),
        .RX_Data(RX_Data), .RX_Empty(RX_Empty), .Data_Read(Data_Read),
        .TX_Data(TX_Data), .TX_Valid(TX_Valid), .TX_Ready(TX_Ready),
        .Grant_err(Grant_err)
    );

    always #5 Clk = ~Clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  mem [256];
    logic [7:0]  rx_q [$];
    logic [15:0] exp_wr [$];
    logic [7:0]  exp_tx [$];
    int          model_idx = 0;
    int          reads = 0;
    int          tx_cnt = 0;
    int          hold_left = 0;
    bit          ack_en = 1'b1;
    int          rq_age = 0;
    int          tx_busy = 0;
    logic        oe_d = 1'b0;
    logic [7:0]  addr_d = 8'h00;
    logic [7:0]  last_tx = 8'h00;
    logic        prev_rq = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Model: each received byte lands at base+index; completing a command appends the flag write.
    task automatic push_rx(input logic [7:0] b);
        rx_q.push_back(b);
        exp_wr.push_back({8'(model_idx), b});
        model_idx++;
        if (model_idx == 3) begin
            exp_wr.push_back({8'h03, 8'hFF});
            model_idx = 0;
        end
    endtask

    // Environment: RAM with one-cycle read latency, RX FIFO, grant responder, UART TX busy for 20 cycles.
    initial forever begin
        @(negedge Clk);
        Data_in = oe_d ? mem[addr_d] : 8'hA5;
        oe_d    = OE;
        addr_d  = Address;
        if (Write_en) mem[Address] = Data_out;
        if (Data_Read && rx_q.size() > 0) void'(rx_q.pop_front());
        RX_Empty = (rx_q.size() == 0);
        RX_Data  = RX_Empty ? 8'h00 : rx_q[0];
        if (!ack_en) begin
            DMA_Ack = 1'b0;
            rq_age  = 0;
        end else if (DMA_RQ) begin
            if (rq_age >= 2) DMA_Ack = 1'b1;
            rq_age++;
        end else begin
            rq_age = 0;
            if (DMA_Ack && hold_left > 0) hold_left--;
            else DMA_Ack = 1'b0;
        end
        if (TX_Valid) tx_busy = 20;
        if (tx_busy > 0) begin
            TX_Ready = 1'b0;
            tx_busy--;
        end else begin
            TX_Ready = 1'b1;
        end
    end

    // Per-cycle compare against the scoreboard and the bus rules.
    initial forever begin
        logic [15:0] w;
        @(posedge Clk);
        #1;
`ifndef DMA_GRANT_TIMEOUT_EN
        chk("grant_err_tied", Grant_err, 0);
`endif
        if (!(DMA_RQ && DMA_Ack))
            chk("bus_idle_no_grant", {Address, Data_out, Write_en, OE}, 0);
        if (Write_en) begin
            chk("wr_expected", exp_wr.size() != 0, 1);
            if (exp_wr.size() != 0) begin
                w = exp_wr.pop_front();
                chk("wr_addr", Address, w[15:8]);
                chk("wr_data", Data_out, w[7:0]);
            end
        end
        if (Data_Read) begin
            reads++;
            chk("pop_with_write", Write_en, 1);
        end
        if (!Rst_n) last_tx = 8'h00;
        if (TX_Valid) begin
            tx_cnt++;
            chk("tx_rq_low", DMA_RQ, 0);
            chk("tx_uart_idle", TX_Ready, 1);
            chk("tx_expected", exp_tx.size() != 0, 1);
            if (exp_tx.size() != 0) chk("tx_data", TX_Data, exp_tx.pop_front());
            last_tx = TX_Data;
        end else begin
            chk("tx_data_hold", TX_Data, last_tx);
        end
        if (DMA_RQ && !prev_rq) chk("rq_on_stale_ack", DMA_Ack, 0);
        prev_rq = DMA_RQ;
        if (READY) chk("ready_quiet", {DMA_RQ, TX_Valid, Write_en, OE}, 0);
    end

    task automatic wait_idle(input string name);
        int  q;
        bit  done;
        q = 0;
        done = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge Clk);
            if (READY && RX_Empty && !DMA_RQ && !DMA_Ack && TX_Ready) q++;
            else q = 0;
            if (q >= 4) begin
                done = 1'b1;
                break;
            end
        end
        chk(name, done, 1);
    endtask

    task automatic pulse_send();
        Send_comm = 1'b1;
        @(negedge Clk);
        Send_comm = 1'b0;
    endtask

    task automatic wait_tx_valid(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge Clk);
            if (TX_Valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk(name, seen, 1);
    endtask

    initial begin
        int r0;
        int t0;
        bit seen;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        repeat (3) @(negedge Clk);
        chk("rst_ready", READY, 1);
        chk("rst_outputs", {DMA_RQ, Address, Data_out, Write_en, OE, Data_Read, TX_Data, TX_Valid, Grant_err}, 0);
        Rst_n = 1'b1;

        // RX: one full command
        push_rx(8'hAB); push_rx(8'hCD); push_rx(8'hEF);
        wait_idle("t1_idle");
        chk("t1_ram0", mem[0], 8'hAB);
        chk("t1_ram1", mem[1], 8'hCD);
        chk("t1_ram2", mem[2], 8'hEF);
        chk("t1_flag", mem[3], 8'hFF);
        chk("t1_reads", reads, 3);
        chk("t1_ready", READY, 1);
        chk("t1_wr_drained", exp_wr.size(), 0);

        // TX: two bytes MSB first
        mem[4] = 8'hAB; mem[5] = 8'hCD;
        exp_tx.push_back(8'hAB); exp_tx.push_back(8'hCD);
        t0 = tx_cnt;
        pulse_send();
        chk("t2_ready_pending", READY, 0);
        wait_idle("t2_idle");
        chk("t2_tx_count", tx_cnt - t0, 2);
        chk("t2_last_byte", TX_Data, 8'hCD);

        // Send_comm during an RX write: current byte completes, TX goes before the next byte
        mem[4] = 8'h33; mem[5] = 8'h44;
        exp_tx.push_back(8'h33); exp_tx.push_back(8'h44);
        r0 = reads;
        push_rx(8'h11); push_rx(8'h22);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge Clk);
            if (Write_en) begin
                seen = 1'b1;
                break;
            end
        end
        chk("t3_saw_write", seen, 1);
        pulse_send();
        wait_tx_valid("t3_tx_seen");
        chk("t3_reads_before_tx", reads - r0, 1);
        wait_idle("t3_idle");
        chk("t3_reads", reads - r0, 2);
        chk("t3_ram0", mem[0], 8'h11);
        chk("t3_ram1", mem[1], 8'h22);

        // Grant held 5 cycles after release with more RX data waiting
        hold_left = 5;
        r0 = reads;
        push_rx(8'h55); push_rx(8'h66);
        wait_idle("t4_idle");
        chk("t4_ram2", mem[2], 8'h55);
        chk("t4_flag", mem[3], 8'hFF);
        chk("t4_ram0", mem[0], 8'h66);
        chk("t4_reads", reads - r0, 2);

        // Reset between MSB and LSB transmit
        mem[4] = 8'h77; mem[5] = 8'h88;
        exp_tx.push_back(8'h77);
        t0 = tx_cnt;
        pulse_send();
        wait_tx_valid("t5_msb_seen");
        repeat (5) @(negedge Clk);
        Rst_n = 1'b0;
        #1;
        chk("t5_rst_outputs", {DMA_RQ, Address, Data_out, Write_en, OE, Data_Read, TX_Data, TX_Valid, Grant_err}, 0);
        chk("t5_rst_ready", READY, 1);
        @(negedge Clk);
        Rst_n = 1'b1;
        model_idx = 0;
        repeat (40) @(negedge Clk);
        push_rx(8'h99);
        wait_idle("t5_idle");
        chk("t5_tx_count", tx_cnt - t0, 1);
        chk("t5_idx_restart", mem[0], 8'h99);

        // Grant never given
        ack_en = 1'b0;
        mem[4] = 8'hA1; mem[5] = 8'hB2;
        exp_tx.push_back(8'hA1); exp_tx.push_back(8'hB2);
        pulse_send();
        repeat (15) @(negedge Clk);
`ifdef DMA_GRANT_TIMEOUT_EN
        chk("t6_grant_err", Grant_err, 1);
`else
        chk("t6_rq_held", DMA_RQ, 1);
        chk("t6_no_err", Grant_err, 0);
        chk("t6_not_ready", READY, 0);
`endif
        ack_en = 1'b1;
        wait_idle("t6_idle");
        chk("t6_tx_drained", exp_tx.size(), 0);

        chk("end_wr_drained", exp_wr.size(), 0);
        chk("end_rx_drained", rx_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dma_ctrl.md
Name: dma_ctrl

Overview:
- DMA controller that moves data between the UART and the shared data RAM.
- RX path: drains received bytes from the UART RX FIFO into a RAM command buffer. Once a full command has been stored, it raises a new-command flag in RAM.
- TX path: on a CPU send command (TYPE_4 instruction), reads the two bytes at DMA_TX_BUFFER_MSB/LSB and sends them MSB first through the UART TX.
- RAM-bus ownership is obtained from the CPU with a request/acknowledge handshake.

Parameters:
- RX_BUF_BASE, 8'h00, RAM address of the first RX command byte.
- RX_BUF_LEN, 3, number of RX bytes per command (1..8).
- NEW_INST_ADDR, 8'h03, RAM address of the new-command flag; written 8'hFF.
- TX_MSB_ADDR, 8'h04, RAM address of DMA_TX_BUFFER_MSB.
- TX_LSB_ADDR, 8'h05, RAM address of DMA_TX_BUFFER_LSB.
- GRANT_TIMEOUT, 255, cycles to wait for DMA_Ack (used only with the optional feature).

Ports:
- Clk  in  1  system clock, rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- Send_comm  in  1  one-cycle pulse from the CPU; requests a TX of the MSB/LSB buffer.
- DMA_RQ  out  1  bus request to the CPU.
- DMA_Ack  in  1  bus grant from the CPU.
- READY  out  1  high when idle with nothing pending.
- Address  out  8  RAM address.
- Data_out  out  8  RAM write data.
- Data_in  in  8  RAM read data; valid 1 cycle after OE.
- Write_en  out  1  RAM write strobe, one cycle per byte.
- OE  out  1  RAM read strobe.
- RX_Data  in  8  head of the UART RX FIFO.
- RX_Empty  in  1  RX FIFO empty.
- Data_Read  out  1  one-cycle pop of the RX FIFO.
- TX_Data  out  8  byte for the UART TX.
- TX_Valid  out  1  one-cycle start pulse to the UART TX.
- TX_Ready  in  1  UART TX idle.
- Grant_err  out  1  sticky timeout flag; tied 0 without the optional feature.

Behaviour:
- Reset: state IDLE.
  - All outputs 0 except READY=1.
  - RX byte index = 0; send-pending flag = 0.
  - Reset mid-operation aborts immediately; no partial RAM write completes afterwards.
- Send_comm is latched into send_pending in any state. It is cleared when TX_REQ is entered.
- READY = (state==IDLE) && !send_pending.
- IDLE:
  - If send_pending, go to TX_REQ (TX has priority).
  - Else if !RX_Empty, go to RX_REQ.
- RX_REQ: DMA_RQ=1; wait for DMA_Ack=1, then go to RX_WR.
- RX_WR (1 cycle):
  - Address = RX_BUF_BASE + idx; Data_out = RX_Data; Write_en=1; Data_Read=1.
  - idx++.
  - If idx reaches RX_BUF_LEN, set idx to 0 and go to RX_FLAG. Otherwise go to RELEASE.
- RX_FLAG (1 cycle): Address = NEW_INST_ADDR; Data_out = 8'hFF; Write_en=1. Then go to RELEASE.
- TX_REQ: DMA_RQ=1; wait for DMA_Ack, then go to RD_MSB.
- RD_MSB: Address = TX_MSB_ADDR; OE=1; go to LAT_MSB.
- LAT_MSB: capture Data_in into a TX holding register; go to RD_LSB.
- RD_LSB: Address = TX_LSB_ADDR; OE=1; go to LAT_LSB.
- LAT_LSB: capture Data_in into a second holding register; go to RELEASE_TX.
- RELEASE_TX: drop DMA_RQ; go to SEND_MSB. The bus is not held during the serial transfer.
- SEND_MSB:
  - When TX_Ready=1: TX_Data = MSB; TX_Valid=1 for one cycle; go to WAIT_MSB.
- WAIT_MSB:
  - Wait until TX_Ready is sampled 0, then wait until it is sampled 1 again; then go to SEND_LSB.
- SEND_LSB / WAIT_LSB: same as SEND_MSB / WAIT_MSB using the LSB; then go to IDLE.
- TX_Data holds its value until the next TX_Valid.
- RELEASE: DMA_RQ=0; wait for DMA_Ack=0, then go to IDLE. This prevents re-requesting on a stale grant.
- Bus outputs (Address, Data_out, Write_en, OE) are 0 whenever the controller does not hold a grant.
- Send_comm during an RX transfer is not lost; the TX starts at the next IDLE.
- Send_comm during a TX is latched, and one more TX follows. Multiple pulses collapse into one.
- idx persists across bus releases, so a command may be spread across several grants.
- Address arithmetic is 8-bit modulo 256.

Optional Feature:
- DMA_GRANT_TIMEOUT_EN defined:
  - In RX_REQ/TX_REQ, a counter runs while DMA_Ack=0.
  - At GRANT_TIMEOUT cycles: set Grant_err (cleared only by reset), drop DMA_RQ, go to IDLE.
  - A timed-out TX sets send_pending again; RX simply retries.
- Not defined: no counter; the controller waits indefinitely; Grant_err is tied to 0.

Test Plan:
- RX FIFO holds AB, CD, EF; bench acks 2 cycles after each DMA_RQ -> RAM[00..02]=AB,CD,EF; RAM[03]=FF; exactly 3 Data_Read pulses; READY=1 at the end.
- RAM[04]=AB, RAM[05]=CD; Send_comm pulse; TX model holds Ready low 20 cycles per byte -> TX_Valid pulses with TX_Data=AB then CD; DMA_RQ low before the first TX_Valid.
- Send_comm pulsed during an RX write while the FIFO is non-empty -> the current RX byte completes, then the TX transfer follows (TX priority at IDLE).
- DMA_Ack held high 5 cycles after DMA_RQ falls -> controller stays in RELEASE and does not re-assert DMA_RQ until DMA_Ack=0.
- Rst_n asserted between MSB and LSB transmit -> all outputs reset immediately, READY=1, RX index=0, no further TX_Valid.
- With DMA_GRANT_TIMEOUT_EN, GRANT_TIMEOUT=10, DMA_Ack never asserted -> Grant_err=1 after 10 cycles and DMA_RQ drops. Without the macro, DMA_RQ stays high and Grant_err=0.
